conv_peak_detect: RTL and testbench

CONV_PEAK_DETECT -- requirements
Module: conv_peak_detect

---
 rtl/conv_peak_detect.sv | 178 +++++++++++++++++
 tb/tb_conv_peak_detect.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_peak_detect.sv
// Per-burst summary of complex results: peak |x|^2 with index, energy sum, count and overflow.
// Summary pulses two edges after the last sample's edge; no backpressure, every valid cycle is accepted.
module conv_peak_detect #(
  parameter int DW      = 18,
  parameter int MAX_LEN = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [2*DW-1:0] in_data,
  output logic            out_valid,
  output logic [2*DW-1:0] out_peak_mag,
  output logic [2:0]      out_peak_idx,
  output logic [2*DW+1:0] out_sum,
  output logic [2:0]      out_cnt,
  output logic            out_ovf
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_REPORT} state_t;

  localparam logic [2:0] LP_MAX_LEN = 3'(MAX_LEN);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_start;
  logic   w_report;

  logic [2:0] r_cnt;
  logic [2:0] w_idx;
  logic       w_excl;

  logic signed [2*DW-1:0] w_re_ext;
  logic signed [2*DW-1:0] w_im_ext;
  logic signed [2*DW-1:0] w_re_sq;
  logic signed [2*DW-1:0] w_im_sq;
  logic        [2*DW-1:0] w_mag;

  logic            r_s1_vld;
  logic [2*DW-1:0] r_s1_mag;
  logic [2:0]      r_s1_idx;
  logic            r_s1_first;
  logic            r_s1_excl;

  logic [2*DW-1:0] r_peak;
  logic [2:0]      r_peak_idx;
  logic [2*DW+1:0] r_sum;
  logic            r_ovf;

  logic            r_out_vld;
  logic [2*DW-1:0] r_out_mag;
  logic [2:0]      r_out_idx;
  logic [2*DW+1:0] r_out_sum;
  logic [2:0]      r_out_cnt;
  logic            r_out_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A valid cycle outside COLLECT always opens a new burst, including the REPORT cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_report    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = S_COLLECT;
          w_start     = 1'b1;
        end
      end
      S_COLLECT: begin
        if (!in_valid) begin
          w_state_nxt = S_REPORT;
        end
      end
      S_REPORT: begin
        w_report = 1'b1;
        if (in_valid) begin
          w_state_nxt = S_COLLECT;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_idx  = w_start ? 3'd0 : r_cnt;
  assign w_excl = (w_idx >= LP_MAX_LEN);

  // Sign-extend before squaring so the full 2*DW-bit product is exact.
  assign w_re_ext = {{DW{in_data[2*DW-1]}}, in_data[2*DW-1:DW]};
  assign w_im_ext = {{DW{in_data[DW-1]}}, in_data[DW-1:0]};
  assign w_re_sq  = w_re_ext * w_re_ext;
  assign w_im_sq  = w_im_ext * w_im_ext;
  assign w_mag    = $unsigned(w_re_sq) + $unsigned(w_im_sq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= 3'd0;
      r_s1_vld   <= 1'b0;
      r_s1_mag   <= '0;
      r_s1_idx   <= 3'd0;
      r_s1_first <= 1'b0;
      r_s1_excl  <= 1'b0;
    end else begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_cnt      <= w_start ? 3'd1 : ((r_cnt == 3'd7) ? 3'd7 : r_cnt + 3'd1);
        r_s1_mag   <= w_mag;
        r_s1_idx   <= w_idx;
        r_s1_first <= w_start;
        r_s1_excl  <= w_excl;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_peak     <= '0;
      r_peak_idx <= 3'd0;
      r_sum      <= '0;
      r_ovf      <= 1'b0;
    end else if (r_s1_vld) begin
      if (r_s1_first) begin
        r_peak     <= r_s1_mag;
        r_peak_idx <= 3'd0;
        r_sum      <= {2'b00, r_s1_mag};
        r_ovf      <= 1'b0;
      end else if (r_s1_excl) begin
        r_ovf <= 1'b1;
      end else begin
        r_sum <= r_sum + {2'b00, r_s1_mag};
        if (r_s1_mag > r_peak) begin
          r_peak     <= r_s1_mag;
          r_peak_idx <= r_s1_idx;
        end
      end
    end
  end

  // Accumulators are final one edge before REPORT is left, so the snapshot is taken there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_out_mag <= '0;
      r_out_idx <= 3'd0;
      r_out_sum <= '0;
      r_out_cnt <= 3'd0;
      r_out_ovf <= 1'b0;
    end else begin
      r_out_vld <= w_report;
      if (w_report) begin
        r_out_mag <= r_peak;
        r_out_idx <= r_peak_idx;
        r_out_sum <= r_sum;
        r_out_cnt <= r_cnt;
        r_out_ovf <= r_ovf;
      end
    end
  end

  assign out_valid    = r_out_vld;
  assign out_peak_mag = r_out_mag;
  assign out_peak_idx = r_out_idx;
  assign out_sum      = r_out_sum;
  assign out_cnt      = r_out_cnt;
  assign out_ovf      = r_out_ovf;

endmodule

// File: tb/tb_conv_peak_detect.sv
// Bench for conv_peak_detect: directed burst table, random bursts against a list-based model,
// continuous hold checking between pulses, and asynchronous reset mid-burst.
module tb_conv_peak_detect;

  localparam int DW      = 18;
  localparam int MAX_LEN = 5;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic [2*DW-1:0] in_data;
  logic            out_valid;
  logic [2*DW-1:0] out_peak_mag;
  logic [2:0]      out_peak_idx;
  logic [2*DW+1:0] out_sum;
  logic [2:0]      out_cnt;
  logic            out_ovf;

  conv_peak_detect #(.DW(DW), .MAX_LEN(MAX_LEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_peak_mag (out_peak_mag),
    .out_peak_idx (out_peak_idx),
    .out_sum      (out_sum),
    .out_cnt      (out_cnt),
    .out_ovf      (out_ovf)
  );

  typedef struct {
    int                   n;
    logic [15:0][DW-1:0]  re;
    logic [15:0][DW-1:0]  im;
  } burst_t;

  typedef struct {
    logic [2*DW-1:0] mag;
    logic [2:0]      idx;
    logic [2*DW+1:0] sum;
    logic [2:0]      cnt;
    logic            ovf;
    int              cyc;
  } exp_t;

  typedef struct {
    burst_t b;
    exp_t   e;
    int     gap;
  } vec_t;

  vec_t tbl[4];
  exp_t q[$];
  exp_t hold;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, longint'(out_valid), 0);
    chk({tag, "_mag"}, longint'(out_peak_mag), 0);
    chk({tag, "_idx"}, longint'(out_peak_idx), 0);
    chk({tag, "_sum"}, longint'(out_sum), 0);
    chk({tag, "_cnt"}, longint'(out_cnt), 0);
    chk({tag, "_ovf"}, longint'(out_ovf), 0);
  endtask

  task automatic mon_step();
    exp_t e;
    if (out_valid) begin
      chk("pulse_expected", longint'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pulse_cyc", cyc, e.cyc);
        chk("pulse_mag", longint'(out_peak_mag), longint'(e.mag));
        chk("pulse_idx", longint'(out_peak_idx), longint'(e.idx));
        chk("pulse_sum", longint'(out_sum), longint'(e.sum));
        chk("pulse_cnt", longint'(out_cnt), longint'(e.cnt));
        chk("pulse_ovf", longint'(out_ovf), longint'(e.ovf));
        hold = e;
      end
    end else begin
      chk("hold_mag", longint'(out_peak_mag), longint'(hold.mag));
      chk("hold_idx", longint'(out_peak_idx), longint'(hold.idx));
      chk("hold_sum", longint'(out_sum), longint'(hold.sum));
      chk("hold_cnt", longint'(out_cnt), longint'(hold.cnt));
      chk("hold_ovf", longint'(out_ovf), longint'(hold.ovf));
    end
  endtask

  // Reference: peak/sum over the first MAX_LEN samples, count capped at 7.
  function automatic exp_t model(input burst_t b);
    exp_t   e;
    longint r;
    longint i2;
    longint m;
    longint pk;
    longint s;
    int     pi;
    pk = 0;
    s  = 0;
    pi = 0;
    for (int i = 0; i < b.n; i++) begin
      r  = $signed(b.re[i]);
      i2 = $signed(b.im[i]);
      m  = r * r + i2 * i2;
      if (i < MAX_LEN) begin
        s = s + m;
        if (i == 0 || m > pk) begin
          pk = m;
          pi = i;
        end
      end
    end
    e.mag = pk[2*DW-1:0];
    e.idx = 3'(pi);
    e.sum = s[2*DW+1:0];
    e.cnt = (b.n > 7) ? 3'd7 : 3'(b.n);
    e.ovf = (b.n > MAX_LEN);
    e.cyc = 0;
    return e;
  endfunction

  task automatic drive(input burst_t b, input exp_t e, input int gap);
    exp_t ee;
    ee = e;
    for (int i = 0; i < b.n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = {b.re[i], b.im[i]};
      if (i == b.n - 1) begin
        ee.cyc = cyc + 3;
        q.push_back(ee);
      end
    end
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = '0;
    end
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 40 && q.size() > 0; k++) @(posedge clk);
    chk({tag, "_drain"}, q.size(), 0);
    @(posedge clk);
  endtask

  task automatic set_s(input int t, input int i, input int re, input int im);
    tbl[t].b.re[i] = DW'(re);
    tbl[t].b.im[i] = DW'(im);
  endtask

  function automatic logic [DW-1:0] rnd_comp(input int mode);
    case (mode)
      0:       return DW'($urandom);
      1:       return DW'($urandom_range(0, 6) - 3);
      2:       return ($urandom_range(0, 1) == 1) ? 18'h20000 : 18'h1FFFF;
      default: return DW'($urandom_range(0, 40) - 20);
    endcase
  endfunction

  initial begin
    burst_t rb;
    exp_t   re_e;
    int     mode;

    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    hold     = '{mag: '0, idx: '0, sum: '0, cnt: '0, ovf: 1'b0, cyc: 0};

    for (int t = 0; t < 4; t++) begin
      tbl[t].b.re = '0;
      tbl[t].b.im = '0;
    end
    // Single sample
    tbl[0].b.n = 1;
    set_s(0, 0, 3, -4);
    tbl[0].e = '{mag: 36'd25, idx: 3'd0, sum: 38'd25, cnt: 3'd1, ovf: 1'b0, cyc: 0};
    tbl[0].gap = 1;
    // Tie between index 2 and 4 keeps index 2
    tbl[1].b.n = 5;
    set_s(1, 0, 1, 0);
    set_s(1, 1, 0, 2);
    set_s(1, 2, 3, 4);
    set_s(1, 3, -3, 0);
    set_s(1, 4, 0, -5);
    tbl[1].e = '{mag: 36'd25, idx: 3'd2, sum: 38'd64, cnt: 3'd5, ovf: 1'b0, cyc: 0};
    tbl[1].gap = 2;
    // Most negative components
    tbl[2].b.n = 5;
    for (int i = 0; i < 5; i++) set_s(2, i, -131072, -131072);
    tbl[2].e = '{mag: 36'd34359738368, idx: 3'd0, sum: 38'd171798691840, cnt: 3'd5,
                 ovf: 1'b0, cyc: 0};
    tbl[2].gap = 3;
    // Overlong burst: large sample beyond MAX_LEN is ignored
    tbl[3].b.n = 8;
    for (int i = 0; i < 8; i++) set_s(3, i, 1, 1);
    set_s(3, 5, 100, 0);
    tbl[3].e = '{mag: 36'd2, idx: 3'd0, sum: 38'd10, cnt: 3'd7, ovf: 1'b1, cyc: 0};
    tbl[3].gap = 5;

    #1 rst = 1'b1;
    #1 chk_zero("reset_init");

    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int t = 0; t < 4; t++) drive(tbl[t].b, tbl[t].e, tbl[t].gap);
    drain("table");

    for (int k = 0; k < 60; k++) begin
      rb.re = '0;
      rb.im = '0;
      rb.n  = $urandom_range(1, 12);
      mode  = $urandom_range(0, 3);
      for (int i = 0; i < rb.n; i++) begin
        rb.re[i] = rnd_comp(mode);
        rb.im[i] = rnd_comp(mode);
      end
      re_e = model(rb);
      drive(rb, re_e, $urandom_range(1, 4));
    end
    drain("random");

    // Mid-burst asynchronous reset discards the partial burst
    drive(tbl[1].b, tbl[1].e, 3);
    drain("pre_reset");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = {tbl[1].b.re[i], tbl[1].b.im[i]};
    end
    @(posedge clk);
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    hold     = '{mag: '0, idx: '0, sum: '0, cnt: '0, ovf: 1'b0, cyc: 0};
    #1 chk_zero("reset_async");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    drive(tbl[0].b, tbl[0].e, 3);
    drain("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
